// File: rtl/div_ctrl_pkg.sv
// Shared types and default width for the sequential restoring divider.
package div_ctrl_pkg;

  localparam int unsigned DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_row.sv
// One restoring-division row: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_row
  import div_ctrl_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic [W:0]   p,
  input  logic         bit_in,
  input  logic [W-1:0] d,
  output logic [W:0]   p_next,
  output logic         q_bit
);

  logic [W:0]   p_shift;
  logic [W+1:0] diff;

  // The borrow out of the W+1-bit subtract is the sign of T.
  always_comb begin
    p_shift = {p[W-1:0], bit_in};
    diff    = {1'b0, p_shift} - {2'b00, d};
    q_bit   = ~diff[W+1];
    p_next  = q_bit ? diff[W:0] : p_shift;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential 2W/W restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional macro DIV_ERR_CHECK_EN: flags divide-by-zero / quotient overflow and skips RUN.
module div_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           err
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  div_state_t     state;
  logic [CW-1:0]  cnt;
  logic [W:0]     p;
  logic [W-1:0]   n_lo;
  logic [W-1:0]   d_reg;
  logic [W-1:0]   q_reg;
  logic [W-1:0]   r_reg;

  logic [W:0]     p_next;
  logic           q_bit;
  logic [W-1:0]   n_lo_next;

  div_row #(.W(W)) u_row (
    .p      (p),
    .bit_in (n_lo[W-1]),
    .d      (d_reg),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  // n_lo feeds dividend bits out of its MSB while quotient bits fill its LSB.
  always_comb begin
    n_lo_next = (n_lo << 1) | W'(q_bit);
  end

`ifdef DIV_ERR_CHECK_EN
  logic err_reg;
  logic ovf;

  always_comb begin
    ovf = (d == '0) || (n[2*W-1:W] >= d);
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      n_lo  <= '0;
      d_reg <= '0;
      q_reg <= '0;
      r_reg <= '0;
`ifdef DIV_ERR_CHECK_EN
      err_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_reg <= d;
            n_lo  <= n[W-1:0];
            p     <= {1'b0, n[2*W-1:W]};
            cnt   <= '0;
`ifdef DIV_ERR_CHECK_EN
            if (ovf) begin
              state   <= DONE;
              q_reg   <= '1;
              r_reg   <= n[W-1:0];
              err_reg <= 1'b1;
            end else begin
              state   <= RUN;
              err_reg <= 1'b0;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          p    <= p_next;
          n_lo <= n_lo_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            q_reg <= n_lo_next;
            r_reg <= p_next[W-1:0];
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign q         = q_reg;
  assign r         = r_reg;

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, setting divisor, quotient and remainder width; the dividend is 2W bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port n, input, 2W bits: the dividend.
REQ-007 The block SHALL have port d, input, W bits: the divisor.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have ports q and r, output, W bits each: the quotient and the remainder.
REQ-011 The block SHALL have port err, output, 1 bit: divide-by-zero or quotient overflow.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an accept occurs when in_valid and in_ready are both 1 on a clock edge.
REQ-014 On accept, the block SHALL register d, the low dividend half n[W-1:0], and the partial remainder P (W+1 bits) = {0, n[2W-1:W]}; it SHALL clear the counter and enter RUN.
REQ-015 Each RUN cycle SHALL do one restoring step, MSB first: P' = {P[W-1:0], next dividend bit}; T = P' - {0,d}; if T is non-negative, the quotient bit is 1 and P = T; otherwise the quotient bit is 0 and P = P'.
REQ-016 RUN SHALL last exactly W cycles, then the block enters DONE; out_valid SHALL first be 1 exactly W+1 edges after the accept edge.
REQ-017 In DONE, out_valid SHALL be 1 and q, r and err SHALL hold stable until out_ready is 1; on that edge the block SHALL return to IDLE.
REQ-018 in_valid SHALL be ignored outside IDLE; operands applied while busy SHALL be neither captured nor queued.
REQ-019 q, r and err SHALL be registered outputs; r SHALL equal P[W-1:0] after the last step.
REQ-020 Only the result from the final step SHALL be exposed; intermediate q and r values are don't-care while out_valid is 0.

Reset
REQ-021 On rst the block SHALL, immediately and regardless of clk, enter IDLE and drive out_valid=0, q=0, r=0, err=0 and counter=0.
REQ-022 in_ready SHALL be 1 from the first edge after reset deassertion.
REQ-023 A reset asserted during RUN or DONE SHALL abort the operation and discard its result, with no out_valid pulse.

Configuration
REQ-024 Macro DIV_ERR_CHECK_EN, when defined, SHALL make an accept with d==0 or n[2W-1:W] >= d go from IDLE straight to DONE on the next edge, with err=1, q = all ones and r = n[W-1:0].
REQ-025 When DIV_ERR_CHECK_EN is not defined, err SHALL be tied to 0 and every accepted operand pair SHALL run the full W-step recurrence, returning whatever that recurrence yields.

Structure
REQ-026 Package div_ctrl_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default-width constant.
REQ-027 The combinational single-row restoring step (a W+1-bit subtract plus restore mux) SHALL be a sub-module named div_row, instantiated once and reused every RUN cycle.
REQ-028 The counter SHALL be $clog2(W)+1 bits wide.

Verification (W=8)
REQ-029 n=0x0064, d=0x07 -> q=0x0E, r=0x02, err=0; out_valid first at edge 9 after accept.
REQ-030 n=0x1234, d=0x56 -> q=0x36, r=0x10; n=0xFEFF, d=0xFF -> q=0xFF, r=0xFE.
REQ-031 With DIV_ERR_CHECK_EN: d=0x00 with n=0x1234 -> err=1, q=0xFF, r=0x34, out_valid at edge 1; n=0x0800, d=0x08 -> err=1.
REQ-032 out_ready held at 0 for 5 cycles in DONE -> q, r and out_valid stable; in_ready=0; new in_valid pulses ignored.
REQ-033 rst pulsed at RUN step 4 -> out_valid=0, q=0, r=0 immediately; the next accept after release runs to a correct result.
REQ-034 Back-to-back operation with in_valid and out_ready held at 1 -> one result per W+2 cycles, all results correct.
